// File: rtl/pc_sequencer.sv
// PC sequencing controller: turns decode class, stage-3 condition results and the BB stall into PC strobes.
// Strobes are combinational from state and inputs; BB holds RUN, and CWAIT/FLUSH/HALTED gate fetch.
module pc_sequencer #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CWAIT_MAX    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [1:0] instr_class,
  input  logic       bb,
  input  logic       halt,
  input  logic       cond_valid,
  input  logic       cond_taken,
  output logic       ipc,
  output logic       dipc,
  output logic       lpc2,
  output logic       lpc3,
  output logic       efl,
  output logic       flush1,
  output logic       flush2,
  output logic [2:0] state,
  output logic       cwait_err
);

  typedef enum logic [2:0] {
    S_RUN    = 3'b000,
    S_CWAIT  = 3'b001,
    S_FLUSH  = 3'b010,
    S_HALTED = 3'b011
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [3:0] CWAIT_LIM  = 4'(CWAIT_MAX);

  state_t     st;
  logic [2:0] fcnt;
  logic [3:0] ccnt;
  logic       run_go;

  assign state  = st;
  // Halt takes priority over a valid instruction, but only once BB has dropped.
  assign run_go = (st == S_RUN) && !bb && !halt && instr_valid;

  always_comb begin
    ipc    = 1'b0;
    dipc   = 1'b0;
    lpc2   = 1'b0;
    lpc3   = 1'b0;
    efl    = 1'b0;
    flush1 = 1'b0;
    flush2 = 1'b0;
    if (!rst) begin
      if (run_go) begin
        case (instr_class)
          2'b00: ipc = 1'b1;
          2'b01: dipc = 1'b1;
          2'b10: begin
            lpc2   = 1'b1;
            flush1 = 1'b1;
          end
          default: dipc = 1'b1;
        endcase
      end
      // BB deliberately does not gate the conditional load.
      if (st == S_CWAIT && cond_valid && cond_taken) begin
        lpc3   = 1'b1;
        efl    = 1'b1;
        flush1 = 1'b1;
        flush2 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_RUN;
      fcnt      <= 3'd0;
      ccnt      <= 4'd0;
      cwait_err <= 1'b0;
    end else begin
      case (st)
        S_RUN: begin
          if (!bb && halt) begin
            st <= S_HALTED;
          end else if (run_go && instr_class == 2'b10) begin
            st   <= S_FLUSH;
            fcnt <= FLUSH_LOAD;
          end else if (run_go && instr_class == 2'b11) begin
            // Counter reads 1 in the first CWAIT cycle.
            st   <= S_CWAIT;
            ccnt <= 4'd1;
          end
        end
        S_CWAIT: begin
          ccnt <= ccnt + 4'd1;
          if (cond_valid) begin
            ccnt <= 4'd0;
            if (cond_taken) begin
              st   <= S_FLUSH;
              fcnt <= FLUSH_LOAD;
            end else begin
              st <= S_RUN;
            end
          end else if (ccnt >= CWAIT_LIM) begin
            ccnt      <= 4'd0;
            cwait_err <= 1'b1;
            st        <= S_RUN;
          end
        end
        S_FLUSH: begin
          if (fcnt <= 3'd1) begin
            fcnt <= 3'd0;
            st   <= S_RUN;
          end else begin
            fcnt <= fcnt - 3'd1;
          end
        end
        S_HALTED: begin
          st <= S_HALTED;
        end
        default: begin
          st   <= S_RUN;
          fcnt <= 3'd0;
          ccnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each stimulus cycle queues its expected outputs; a monitor checks them.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [1:0] instr_class;
  logic       bb, halt, cond_valid, cond_taken;
  logic       ipc, dipc, lpc2, lpc3, efl, flush1, flush2;
  logic [2:0] state;
  logic       cwait_err;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];
  string       name_q[$];

  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] IPC   = 7'b1000000;
  localparam logic [6:0] DIPC  = 7'b0100000;
  localparam logic [6:0] UNC   = 7'b0010010;
  localparam logic [6:0] TAKEN = 7'b0001111;
  localparam logic [2:0] RUN = 3'b000, CW = 3'b001, FL = 3'b010, HL = 3'b011;

  pc_sequencer #(.FLUSH_CYCLES(2), .CWAIT_MAX(4)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_class(instr_class),
    .bb(bb), .halt(halt), .cond_valid(cond_valid), .cond_taken(cond_taken),
    .ipc(ipc), .dipc(dipc), .lpc2(lpc2), .lpc3(lpc3), .efl(efl),
    .flush1(flush1), .flush2(flush2), .state(state), .cwait_err(cwait_err)
  );

  always #5 clk = ~clk;

  // in = {rst, instr_valid, class[1:0], bb, halt, cond_valid, cond_taken}
  task automatic step(input logic [7:0] in, input logic [6:0] strb,
                      input logic [2:0] st, input logic err, input string nm);
    @(posedge clk);
    #1;
    {rst, instr_valid, instr_class, bb, halt, cond_valid, cond_taken} = in;
    exp_q.push_back({strb, st, err});
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are presented every cycle, checked mid-cycle.
  initial begin
    logic [10:0] got, want;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        got  = {ipc, dipc, lpc2, lpc3, efl, flush1, flush2, state, cwait_err};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s: got %b required %b ({ipc,dipc,lpc2,lpc3,efl,f1,f2,state,err})",
                   nm, got, want);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    {rst, instr_valid, instr_class, bb, halt, cond_valid, cond_taken} = 8'b1000_0000;
    step(8'b1000_0000, NONE, RUN, 1'b0, "reset_state");
    step(8'b0100_0000, IPC,  RUN, 1'b0, "class00_ipc");
    step(8'b0101_0000, DIPC, RUN, 1'b0, "class01_dipc");
    step(8'b0100_0000, IPC,  RUN, 1'b0, "class00_ipc_again");
    step(8'b1100_0000, NONE, RUN, 1'b0, "reset_midstream_zero");
    // Unconditional branch, two dead cycles with inputs ignored
    step(8'b0110_0000, UNC,  RUN, 1'b0, "uncond_lpc2");
    step(8'b0100_0000, NONE, FL,  1'b0, "flush_dead1");
    step(8'b0100_0110, NONE, FL,  1'b0, "flush_dead2_ignores");
    step(8'b0100_0000, IPC,  RUN, 1'b0, "after_flush_ipc");
    // Conditional taken, BB does not gate the load
    step(8'b0111_0000, DIPC, RUN, 1'b0, "cond_dipc");
    step(8'b0100_0000, NONE, CW,  1'b0, "cwait_no_ipc");
    step(8'b0000_1011, TAKEN, CW, 1'b0, "cond_taken_lpc3");
    step(8'b0100_0000, NONE, FL,  1'b0, "taken_flush1");
    step(8'b0100_0000, NONE, FL,  1'b0, "taken_flush2");
    // Conditional not taken
    step(8'b0111_0000, DIPC, RUN, 1'b0, "cond2_dipc");
    step(8'b0000_0010, NONE, CW,  1'b0, "not_taken_quiet");
    step(8'b0100_0000, IPC,  RUN, 1'b0, "not_taken_run");
    // Timeout after four CWAIT cycles
    step(8'b0111_0000, DIPC, RUN, 1'b0, "cond3_dipc");
    step(8'b0000_0100, NONE, CW,  1'b0, "cwait_c1_halt_ignored");
    step(8'b0000_0000, NONE, CW,  1'b0, "cwait_c2");
    step(8'b0000_0000, NONE, CW,  1'b0, "cwait_c3");
    step(8'b0000_0000, NONE, CW,  1'b0, "cwait_c4");
    step(8'b0000_0000, NONE, RUN, 1'b1, "timeout_err");
    step(8'b0100_0000, IPC,  RUN, 1'b1, "err_sticky");
    step(8'b1000_0000, NONE, RUN, 1'b0, "rst_clears_err");
    // Resolution on the limit cycle beats the timeout
    step(8'b0111_0000, DIPC, RUN, 1'b0, "cond4_dipc");
    step(8'b0000_0000, NONE, CW,  1'b0, "edge_c1");
    step(8'b0000_0000, NONE, CW,  1'b0, "edge_c2");
    step(8'b0000_0000, NONE, CW,  1'b0, "edge_c3");
    step(8'b0000_0010, NONE, CW,  1'b0, "edge_c4_resolve");
    step(8'b0000_0000, NONE, RUN, 1'b0, "edge_no_err");
    // Stall and halt interaction
    step(8'b0100_1000, NONE, RUN, 1'b0, "bb_stall");
    step(8'b0110_1000, NONE, RUN, 1'b0, "bb_stall_branch");
    step(8'b0100_1100, NONE, RUN, 1'b0, "halt_deferred_by_bb");
    step(8'b0100_0100, NONE, RUN, 1'b0, "halt_priority");
    step(8'b0100_0000, NONE, HL,  1'b0, "halted_no_ipc");
    step(8'b0110_0000, NONE, HL,  1'b0, "halted_no_lpc2");
    step(8'b0000_0011, NONE, HL,  1'b0, "halted_no_lpc3");
    step(8'b0000_0000, NONE, HL,  1'b0, "halted_stays");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
